riscv_if_pq: RTL and testbench

Parametrised instruction-fetch parcel queue for the RISC-V core front-end. It sits between the instruction BIU/cache and the decode stage, and buffers incoming fetch parcels as a queue of 16-bit halfword slots. It aligns 16-bit (RVC) and 32-bit instructions across parcel boundaries, including 32-bit instructions that straddle two parcels. It drops stale parcels after a redirect and carries per-halfword fetch exceptions through to the instruction that uses them.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/riscv_if_aligner.sv | 47 ++++
 rtl/riscv_if_pq.sv | 185 ++++++++++++++++++
 tb/tb_riscv_if_pq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared front-end definitions: exception cause indices and the parcel-queue slot layout.
package riscv_pkg;

    localparam int unsigned CAUSE_MISALIGNED_INSTRUCTION   = 0;
    localparam int unsigned CAUSE_INSTRUCTION_ACCESS_FAULT = 1;
    localparam int unsigned CAUSE_ILLEGAL_INSTRUCTION      = 2;

    // One halfword slot of the parcel queue with its fetch status
    typedef struct packed {
        logic [15:0] data;
        logic        mis;
        logic        flt;
    } pq_slot_t;

endpackage

// File: rtl/riscv_if_aligner.sv
// Combinational head inspection: decides whether the two head slots form an instruction.
module riscv_if_aligner
    import riscv_pkg::*;
#(
    parameter int unsigned PTR_W          = 4,
    parameter int unsigned EXCEPTION_SIZE = 16,
    parameter bit          HAS_RVC        = 1'b1
) (
    input  pq_slot_t                  slot0_i,
    input  pq_slot_t                  slot1_i,
    input  logic [PTR_W-1:0]          count_i,
    output logic                      formable_c_o,
    output logic                      is_rvc_c_o,
    output logic [1:0]                pop_cnt_c_o,
    output logic [31:0]               instr_c_o,
    output logic [EXCEPTION_SIZE-1:0] exception_c_o
);

    // Faulted head first, then 16-bit, then 32-bit once both halves are present
    always_comb begin
        formable_c_o  = 1'b0;
        is_rvc_c_o    = 1'b0;
        pop_cnt_c_o   = 2'd0;
        instr_c_o     = '0;
        exception_c_o = '0;
        if (count_i != '0) begin
            if (slot0_i.mis || slot0_i.flt) begin
                formable_c_o = 1'b1;
                pop_cnt_c_o  = 2'd1;
                exception_c_o[CAUSE_MISALIGNED_INSTRUCTION]   = slot0_i.mis;
                exception_c_o[CAUSE_INSTRUCTION_ACCESS_FAULT] = slot0_i.flt;
            end else if (slot0_i.data[1:0] != 2'b11) begin
                formable_c_o = 1'b1;
                is_rvc_c_o   = 1'b1;
                pop_cnt_c_o  = 2'd1;
                instr_c_o    = {16'h0000, slot0_i.data};
                exception_c_o[CAUSE_ILLEGAL_INSTRUCTION] = !HAS_RVC;
            end else if (count_i >= PTR_W'(2)) begin
                formable_c_o = 1'b1;
                pop_cnt_c_o  = 2'd2;
                instr_c_o    = {slot1_i.data, slot0_i.data};
                exception_c_o[CAUSE_INSTRUCTION_ACCESS_FAULT] = slot1_i.flt;
            end
        end
    end

endmodule

// File: rtl/riscv_if_pq.sv
// Instruction-fetch parcel queue: halfword FIFO between fetch and decode with RVC/32-bit alignment.
module riscv_if_pq
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN           = 64,
    parameter int unsigned     PARCEL_SIZE    = 32,
    parameter int unsigned     QUEUE_DEPTH    = 8,
    parameter int unsigned     EXCEPTION_SIZE = 16,
    parameter bit              HAS_RVC        = 1'b1,
    parameter logic [XLEN-1:0] PC_INIT        = XLEN'('h8000_0000)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PARCEL_SIZE-1:0]    pq_parcel,
    input  logic [XLEN-1:0]           pq_parcel_pc,
    input  logic [PARCEL_SIZE/16-1:0] pq_parcel_valid,
    input  logic                      pq_parcel_misaligned,
    input  logic                      pq_parcel_page_fault,
    output logic                      pq_ready,
    input  logic                      flush,
    input  logic [XLEN-1:0]           flush_pc,
    input  logic                      id_ready,
    output logic                      if_valid,
    output logic [31:0]               if_instr,
    output logic                      if_is_rvc,
    output logic [XLEN-1:0]           if_pc,
    output logic [EXCEPTION_SIZE-1:0] if_exception
);

    localparam int unsigned HW_PER_PARCEL = PARCEL_SIZE / 16;
    localparam int unsigned IDX_W         = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTR_W         = IDX_W + 1;

    pq_slot_t                  mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    logic [XLEN-1:0]           head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic                      if_valid_q, if_valid_d;
    logic [31:0]               if_instr_q, if_instr_d;
    logic                      if_is_rvc_q, if_is_rvc_d;
    logic [XLEN-1:0]           if_pc_q, if_pc_d;
    logic [EXCEPTION_SIZE-1:0] if_exception_q, if_exception_d;

    logic [PTR_W-1:0]          first_idx, n_valid;
    logic                      first_found;
    logic [XLEN-1:0]           first_pc;
    logic                      push;
    logic [IDX_W-1:0]          wr_slot [HW_PER_PARCEL];
    logic [IDX_W-1:0]          rd_idx0, rd_idx1;

    logic                      al_formable, al_is_rvc;
    logic [1:0]                al_pop;
    logic [31:0]               al_instr;
    logic [EXCEPTION_SIZE-1:0] al_exc;
    logic                      pop_en;

    assign count    = wr_ptr_q - rd_ptr_q;
    // Pre-pop occupancy: ready only when a whole parcel is guaranteed to fit
    assign pq_ready = (PTR_W'(QUEUE_DEPTH) - count) >= PTR_W'(HW_PER_PARCEL);

    // Locate the first valid halfword and count the valid ones (valid bits are contiguous)
    always_comb begin
        first_idx   = '0;
        n_valid     = '0;
        first_found = 1'b0;
        for (int i = 0; i < HW_PER_PARCEL; i++) begin
            if (pq_parcel_valid[i]) begin
                if (!first_found) begin
                    first_idx   = PTR_W'(i);
                    first_found = 1'b1;
                end
                n_valid = n_valid + PTR_W'(1);
            end
        end
    end

    assign first_pc = pq_parcel_pc + (XLEN'(first_idx) << 1);
    // Stale parcels (address not the expected next fetch) are dropped here
    assign push     = pq_ready && (|pq_parcel_valid) && (first_pc == tail_pc_q) && !flush;

    // Queue slot targeted by each parcel halfword, packed down past leading invalid ones
    always_comb begin
        for (int i = 0; i < HW_PER_PARCEL; i++) begin
            wr_slot[i] = IDX_W'(wr_ptr_q[IDX_W-1:0] + IDX_W'(i) - IDX_W'(first_idx));
        end
    end

    // Halfword storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < HW_PER_PARCEL; i++) begin
                if (pq_parcel_valid[i]) begin
                    mem_q[wr_slot[i]] <= {pq_parcel[16*i +: 16], pq_parcel_misaligned, pq_parcel_page_fault};
                end
            end
        end
    end

    assign rd_idx0 = rd_ptr_q[IDX_W-1:0];
    assign rd_idx1 = rd_idx0 + IDX_W'(1);

    riscv_if_aligner #(
        .PTR_W          (PTR_W),
        .EXCEPTION_SIZE (EXCEPTION_SIZE),
        .HAS_RVC        (HAS_RVC)
    ) u_aligner (
        .slot0_i       (mem_q[rd_idx0]),
        .slot1_i       (mem_q[rd_idx1]),
        .count_i       (count),
        .formable_c_o  (al_formable),
        .is_rvc_c_o    (al_is_rvc),
        .pop_cnt_c_o   (al_pop),
        .instr_c_o     (al_instr),
        .exception_c_o (al_exc)
    );

    assign pop_en = al_formable && (!if_valid_q || id_ready);

    // Next-state: flush overrides; otherwise independent push and pop
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        head_pc_d      = head_pc_q;
        tail_pc_d      = tail_pc_q;
        if_valid_d     = if_valid_q;
        if_instr_d     = if_instr_q;
        if_is_rvc_d    = if_is_rvc_q;
        if_pc_d        = if_pc_q;
        if_exception_d = if_exception_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            head_pc_d  = flush_pc;
            tail_pc_d  = flush_pc;
            if_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + n_valid;
                tail_pc_d = tail_pc_q + (XLEN'(n_valid) << 1);
            end
            if (pop_en) begin
                rd_ptr_d       = rd_ptr_q + PTR_W'(al_pop);
                head_pc_d      = head_pc_q + (XLEN'(al_pop) << 1);
                if_valid_d     = 1'b1;
                if_instr_d     = al_instr;
                if_is_rvc_d    = al_is_rvc;
                if_pc_d        = head_pc_q;
                if_exception_d = al_exc;
            end else if (id_ready) begin
                if_valid_d = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            head_pc_q      <= PC_INIT;
            tail_pc_q      <= PC_INIT;
            if_valid_q     <= 1'b0;
            if_instr_q     <= '0;
            if_is_rvc_q    <= 1'b0;
            if_pc_q        <= PC_INIT;
            if_exception_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            head_pc_q      <= head_pc_d;
            tail_pc_q      <= tail_pc_d;
            if_valid_q     <= if_valid_d;
            if_instr_q     <= if_instr_d;
            if_is_rvc_q    <= if_is_rvc_d;
            if_pc_q        <= if_pc_d;
            if_exception_q <= if_exception_d;
        end
    end

    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_is_rvc    = if_is_rvc_q;
    assign if_pc        = if_pc_q;
    assign if_exception = if_exception_q;

endmodule

// File: tb/tb_riscv_if_pq.sv
// Scoreboard bench: two queues (RVC enabled / disabled) driven by identical fetch traffic.
module tb_riscv_if_pq;

    localparam logic [15:0] EXC_MIS = 16'h0001;
    localparam logic [15:0] EXC_FLT = 16'h0002;
    localparam logic [15:0] EXC_ILL = 16'h0004;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        rvc;
        logic [15:0] exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pq_parcel = '0;
    logic [63:0] pq_parcel_pc = '0;
    logic [1:0]  pq_parcel_valid = '0;
    logic        pq_parcel_misaligned = 1'b0;
    logic        pq_parcel_page_fault = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] flush_pc = '0;
    logic        id_ready = 1'b1;

    logic        a_ready, a_valid, a_rvc;
    logic [31:0] a_instr;
    logic [63:0] a_pc;
    logic [15:0] a_exc;
    logic        b_ready, b_valid, b_rvc;
    logic [31:0] b_instr;
    logic [63:0] b_pc;
    logic [15:0] b_exc;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    riscv_if_pq #(.HAS_RVC(1'b1)) dut (
        .clk(clk), .rstn(rstn),
        .pq_parcel(pq_parcel), .pq_parcel_pc(pq_parcel_pc), .pq_parcel_valid(pq_parcel_valid),
        .pq_parcel_misaligned(pq_parcel_misaligned), .pq_parcel_page_fault(pq_parcel_page_fault),
        .pq_ready(a_ready), .flush(flush), .flush_pc(flush_pc), .id_ready(id_ready),
        .if_valid(a_valid), .if_instr(a_instr), .if_is_rvc(a_rvc), .if_pc(a_pc), .if_exception(a_exc)
    );

    riscv_if_pq #(.HAS_RVC(1'b0)) dut_norvc (
        .clk(clk), .rstn(rstn),
        .pq_parcel(pq_parcel), .pq_parcel_pc(pq_parcel_pc), .pq_parcel_valid(pq_parcel_valid),
        .pq_parcel_misaligned(pq_parcel_misaligned), .pq_parcel_page_fault(pq_parcel_page_fault),
        .pq_ready(b_ready), .flush(flush), .flush_pc(flush_pc), .id_ready(id_ready),
        .if_valid(b_valid), .if_instr(b_instr), .if_is_rvc(b_rvc), .if_pc(b_pc), .if_exception(b_exc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected decode-side output; the RVC-disabled queue flags every 16-bit encoding illegal
    task automatic exp_out(input logic [31:0] instr, input logic [63:0] pc, input logic rvc, input logic [15:0] exc);
        qa.push_back('{instr, pc, rvc, exc});
        qb.push_back('{instr, pc, rvc, rvc ? (exc | EXC_ILL) : exc});
    endtask

    // Monitor for the RVC-enabled queue: one comparison set per decode handshake
    always @(negedge clk) begin
        if (rstn && a_valid && id_ready) begin
            exp_t e;
            if (qa.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected: got instr 0x%0h pc 0x%0h, expected no output", a_instr, a_pc);
            end else begin
                e = qa.pop_front();
                chk("a_instr", 64'(a_instr), 64'(e.instr));
                chk("a_pc", a_pc, e.pc);
                chk("a_is_rvc", 64'(a_rvc), 64'(e.rvc));
                chk("a_exception", 64'(a_exc), 64'(e.exc));
            end
        end
    end

    // Monitor for the RVC-disabled queue
    always @(negedge clk) begin
        if (rstn && b_valid && id_ready) begin
            exp_t e;
            if (qb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected: got instr 0x%0h pc 0x%0h, expected no output", b_instr, b_pc);
            end else begin
                e = qb.pop_front();
                chk("b_instr", 64'(b_instr), 64'(e.instr));
                chk("b_pc", b_pc, e.pc);
                chk("b_is_rvc", 64'(b_rvc), 64'(e.rvc));
                chk("b_exception", 64'(b_exc), 64'(e.exc));
            end
        end
    end

    // Present one parcel; hold it until the queue reports ready, then for one accepting edge
    task automatic push(input logic [63:0] pc, input logic [31:0] data, input logic [1:0] v,
                        input logic mis, input logic flt);
        int w = 0;
        pq_parcel            = data;
        pq_parcel_pc         = pc;
        pq_parcel_valid      = v;
        pq_parcel_misaligned = mis;
        pq_parcel_page_fault = flt;
        while (!a_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (!a_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: pq_ready stayed 0 for pc 0x%0h, expected 1", pc);
        end
        @(posedge clk); #1;
        pq_parcel_valid      = '0;
        pq_parcel_misaligned = 1'b0;
        pq_parcel_page_fault = 1'b0;
    endtask

    task automatic do_flush(input logic [63:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk); #1;
        flush    = 1'b0;
    endtask

    // Wait (bounded) until every expected output was seen, then let the pipe settle
    task automatic drain(input string name);
        int w = 0;
        while ((qa.size() != 0 || qb.size() != 0) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d/%0d outputs pending, expected 0", name, qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset state
        chk("rst_if_valid", 64'(a_valid), 64'(0));
        chk("rst_if_instr", 64'(a_instr), 64'(0));
        chk("rst_if_is_rvc", 64'(a_rvc), 64'(0));
        chk("rst_if_pc", a_pc, 64'h8000_0000);
        chk("rst_if_exception", 64'(a_exc), 64'(0));
        chk("rst_pq_ready", 64'(a_ready), 64'(1));

        // Straddling RVC/32-bit sequence
        exp_out(32'h0000_4501, 64'h8000_0000, 1'b1, 16'h0);
        exp_out(32'h0000_0001, 64'h8000_0002, 1'b1, 16'h0);
        exp_out(32'h0000_0013, 64'h8000_0004, 1'b0, 16'h0);
        push(64'h8000_0000, 32'h0001_4501, 2'b11, 1'b0, 1'b0);
        push(64'h8000_0004, 32'h0000_0013, 2'b11, 1'b0, 1'b0);
        drain("straddle");

        // 32-bit instruction split across two parcels
        exp_out(32'h0000_4501, 64'h8000_0008, 1'b1, 16'h0);
        exp_out(32'h0010_0513, 64'h8000_000A, 1'b0, 16'h0);
        exp_out(32'h0000_0001, 64'h8000_000E, 1'b1, 16'h0);
        push(64'h8000_0008, 32'h0513_4501, 2'b11, 1'b0, 1'b0);
        push(64'h8000_000C, 32'h0001_0010, 2'b11, 1'b0, 1'b0);
        drain("split32");

        // Flush while holding slots, then a stale parcel must vanish
        id_ready = 1'b0;
        push(64'h8000_0010, 32'h0001_0001, 2'b11, 1'b0, 1'b0);
        push(64'h8000_0014, 32'h0001_0001, 2'b11, 1'b0, 1'b0);
        chk("hold_valid_before_flush", 64'(a_valid), 64'(1));
        do_flush(64'h8000_0100);
        chk("flush_clears_valid", 64'(a_valid), 64'(0));
        chk("flush_ready", 64'(a_ready), 64'(1));
        id_ready = 1'b1;
        push(64'h8000_0008, 32'h0001_0001, 2'b11, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("stale_no_valid", 64'(a_valid), 64'(0));
        exp_out(32'h0000_4501, 64'h8000_0100, 1'b1, 16'h0);
        exp_out(32'h0000_0001, 64'h8000_0102, 1'b1, 16'h0);
        push(64'h8000_0100, 32'h0001_4501, 2'b11, 1'b0, 1'b0);
        drain("flush");

        // Redirect into the middle of a parcel: only the upper halfword is valid
        do_flush(64'h8000_0202);
        exp_out(32'h0000_4505, 64'h8000_0202, 1'b1, 16'h0);
        push(64'h8000_0200, 32'h4505_FFFF, 2'b10, 1'b0, 1'b0);
        drain("partial");

        // Backpressure: fill the queue with 32-bit instructions while decode stalls
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_out(32'h0000_0013 | (32'(i) << 20), 64'h8000_0204 + 64'(4 * i), 1'b0, 16'h0);
            push(64'h8000_0204 + 64'(4 * i), 32'h0000_0013 | (32'(i) << 20), 2'b11, 1'b0, 1'b0);
        end
        chk("bp_ready_low", 64'(a_ready), 64'(0));
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("bp_hold_valid", 64'(a_valid), 64'(1));
        chk("bp_hold_instr", 64'(a_instr), 64'h13);
        chk("bp_hold_pc", a_pc, 64'h8000_0204);
        chk("bp_ready_still_low", 64'(a_ready), 64'(0));
        id_ready = 1'b1;
        for (int i = 5; i < 7; i++) begin
            exp_out(32'h0000_0013 | (32'(i) << 20), 64'h8000_0204 + 64'(4 * i), 1'b0, 16'h0);
            push(64'h8000_0204 + 64'(4 * i), 32'h0000_0013 | (32'(i) << 20), 2'b11, 1'b0, 1'b0);
        end
        drain("backpressure");

        // Fault on the second half of a 32-bit instruction, then faulted/misaligned heads
        exp_out(32'h0000_0001, 64'h8000_0220, 1'b1, 16'h0);
        exp_out(32'h0010_0513, 64'h8000_0222, 1'b0, EXC_FLT);
        exp_out(32'h0000_0000, 64'h8000_0226, 1'b0, EXC_FLT);
        exp_out(32'h0000_0000, 64'h8000_0228, 1'b0, EXC_MIS);
        exp_out(32'h0000_0000, 64'h8000_022A, 1'b0, EXC_MIS);
        push(64'h8000_0220, 32'h0513_0001, 2'b11, 1'b0, 1'b0);
        push(64'h8000_0224, 32'h0001_0010, 2'b11, 1'b0, 1'b1);
        push(64'h8000_0228, 32'h0001_0001, 2'b11, 1'b1, 1'b0);
        drain("faults");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
